// File: rtl/discharge_state_detector_pkg.sv
// Shared codes and default thresholds for the EDM gap discharge detector.
// Imported by the detector, pulse generator and servo logic.
package discharge_state_detector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_SPARK = 3'd2,
    ST_SHORT = 3'd3,
    ST_DONE  = 3'd4
  } gap_state_e;

  typedef enum logic [1:0] {
    RES_OPEN   = 2'd0,
    RES_NORMAL = 2'd1,
    RES_ARC    = 2'd2,
    RES_SHORT  = 2'd3
  } result_e;

  localparam int I_ON_TH_DEF       = 2;
  localparam int V_SHORT_TH_DEF    = 5;
  localparam int DEBOUNCE_DEF      = 3;
  localparam int ARC_DELAY_DEF     = 10;
  localparam int SHORT_ALARM_N_DEF = 4;
  localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/discharge_state_detector_filter.sv
// Consecutive-sample run counter; confirm fires on the sample where
// the run reaches DEBOUNCE.
module consec_filter #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  input  logic flush_i,
  input  logic qual_i,
  output logic confirm_o
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [3:0] run_q;
  logic [3:0] run_d;
  logic [3:0] base;
  logic [3:0] inc;

  // restart treats the previous run as empty so this sample still counts
  assign base = restart_i ? 4'd0 : run_q;
  assign inc  = (base == 4'hF) ? base : base + 4'd1;

  assign confirm_o = en_i && qual_i && (inc == DB);

  always_comb begin
    run_d = 4'd0;
    if (en_i && qual_i && !flush_i) begin
      run_d = inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q <= 4'd0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/discharge_state_detector.sv
// Per-pulse gap classifier: OPEN / NORMAL / ARC / SHORT with ignition
// delay, discharge length and repeated-short alarm.
module discharge_state_detector
  import discharge_state_detector_pkg::*;
#(
  parameter int I_ON_TH       = I_ON_TH_DEF,
  parameter int V_SHORT_TH    = V_SHORT_TH_DEF,
  parameter int DEBOUNCE      = DEBOUNCE_DEF,
  parameter int ARC_DELAY     = ARC_DELAY_DEF,
  parameter int SHORT_ALARM_N = SHORT_ALARM_N_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             ad_clk,
  input  logic             rst,
  input  logic             pulse_on,
  input  logic [15:0]      sample_current,
  input  logic [15:0]      sample_voltage,
  output logic             result_valid,
  output logic [1:0]       result_type,
  output logic [CNT_W-1:0] ignition_delay,
  output logic [CNT_W-1:0] discharge_len,
  output logic [2:0]       gap_state,
  output logic             short_alarm
);

  localparam logic signed [15:0] I_TH    = 16'(I_ON_TH);
  localparam logic signed [15:0] V_TH    = 16'(V_SHORT_TH);
  localparam logic [CNT_W-1:0]   ARC_TH  = CNT_W'(ARC_DELAY);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [7:0]         ALARM_N = 8'(SHORT_ALARM_N);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  gap_state_e       state_q, state_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] disch_q, disch_d;
  logic [CNT_W-1:0] ign_q, ign_d;
  logic             arc_q, arc_d;
  logic             valid_q, valid_d;
  logic [1:0]       type_q, type_d;
  logic [CNT_W-1:0] idel_q, idel_d;
  logic [CNT_W-1:0] dlen_q, dlen_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             alarm_q, alarm_d;

  logic             cur_ok, short_ok;
  logic             cur_en, sh_en, flush;
  logic             cur_conf, sh_conf;
  logic             fin;
  result_e          fin_type;
  logic [CNT_W-1:0] fin_idel, fin_dlen;
  logic [CNT_W-1:0] delay_nx;

  assign cur_ok   = $signed(sample_current) >= I_TH;
  assign short_ok = $signed(sample_voltage) <= V_TH;

  assign cur_en = pulse_on &&
                  (state_q == ST_IDLE || state_q == ST_OPEN);
  assign sh_en  = pulse_on && (state_q == ST_SPARK);

  // IDLE->OPEN keeps the first sample's run; other moves restart filters
  assign flush = (state_d != state_q) &&
                 !(state_q == ST_IDLE && state_d == ST_OPEN);

  assign delay_nx = (state_q == ST_IDLE) ? CNT_ONE : sat_inc(delay_q);

  consec_filter #(.DEBOUNCE(DEBOUNCE)) u_cur_filt (
    .clk_i     (ad_clk),
    .rst_i     (rst),
    .en_i      (cur_en),
    .restart_i (state_q == ST_IDLE),
    .flush_i   (flush),
    .qual_i    (cur_ok),
    .confirm_o (cur_conf)
  );

  consec_filter #(.DEBOUNCE(DEBOUNCE)) u_sh_filt (
    .clk_i     (ad_clk),
    .rst_i     (rst),
    .en_i      (sh_en),
    .restart_i (1'b0),
    .flush_i   (flush),
    .qual_i    (short_ok),
    .confirm_o (sh_conf)
  );

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    disch_d  = disch_q;
    ign_d    = ign_q;
    arc_d    = arc_q;
    valid_d  = 1'b0;
    type_d   = type_q;
    idel_d   = idel_q;
    dlen_d   = dlen_q;
    scnt_d   = scnt_q;
    alarm_d  = alarm_q;
    fin      = 1'b0;
    fin_type = RES_OPEN;
    fin_idel = delay_q;
    fin_dlen = '0;

    unique case (state_q)
      ST_IDLE, ST_OPEN: begin
        if (pulse_on) begin
          state_d = ST_OPEN;
          delay_d = delay_nx;
          if (state_q == ST_IDLE) begin
            disch_d = '0;
            ign_d   = '0;
            arc_d   = 1'b0;
          end
          if (cur_conf) begin
            ign_d   = delay_nx;
            arc_d   = delay_nx < ARC_TH;
            state_d = short_ok ? ST_SHORT : ST_SPARK;
          end
        end else if (state_q == ST_OPEN) begin
          fin = 1'b1;
        end
      end
      ST_SPARK: begin
        if (pulse_on) begin
          disch_d = sat_inc(disch_q);
          if (sh_conf) state_d = ST_SHORT;
        end else begin
          fin      = 1'b1;
          fin_type = arc_q ? RES_ARC : RES_NORMAL;
          fin_idel = ign_q;
          fin_dlen = disch_q;
        end
      end
      ST_SHORT: begin
        if (!pulse_on) begin
          fin      = 1'b1;
          fin_type = RES_SHORT;
          fin_idel = ign_q;
          fin_dlen = disch_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d = ST_DONE;
      valid_d = 1'b1;
      type_d  = fin_type;
      idel_d  = fin_idel;
      dlen_d  = fin_dlen;
      if (fin_type == RES_SHORT) begin
        scnt_d = (scnt_q == ALARM_N) ? scnt_q : scnt_q + 8'd1;
      end else begin
        scnt_d = 8'd0;
      end
      alarm_d = (scnt_d == ALARM_N);
    end
  end

  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      disch_q <= '0;
      ign_q   <= '0;
      arc_q   <= 1'b0;
      valid_q <= 1'b0;
      type_q  <= 2'd0;
      idel_q  <= '0;
      dlen_q  <= '0;
      scnt_q  <= 8'd0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      disch_q <= disch_d;
      ign_q   <= ign_d;
      arc_q   <= arc_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      idel_q  <= idel_d;
      dlen_q  <= dlen_d;
      scnt_q  <= scnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign result_valid   = valid_q;
  assign result_type    = type_q;
  assign ignition_delay = idel_q;
  assign discharge_len  = dlen_q;
  assign gap_state      = state_q;
  assign short_alarm    = alarm_q;

endmodule

// File: doc/discharge_state_detector.md
Name: discharge_state_detector

Overview:
- Consumes the scaled gap voltage (V) and board current (A) produced by the sample-to-real-value stage on ad_clk.
- Classifies each machining pulse as OPEN, NORMAL spark, ARC or SHORT.
- Measures ignition delay and discharge length per pulse.
- Raises a short alarm for the servo/pulse-generator logic after repeated shorts.

Parameters:
- I_ON_TH, 2: signed current (A) at or above which discharge current is considered flowing.
- V_SHORT_TH, 5: signed voltage (V) at or below which the gap is considered shorted.
- DEBOUNCE, 3: consecutive qualifying samples needed to confirm any condition (range 1..15).
- ARC_DELAY, 10: ignition delay (cycles) strictly below which a spark is classified ARC.
- SHORT_ALARM_N, 4: consecutive SHORT results that raise short_alarm.
- CNT_W, 16: width of the delay and length counters.

Ports:
- ad_clk  in  1  50 MHz sample clock.
- rst  in  1  asynchronous, active-high reset.
- pulse_on  in  1  pulse-generator on-window, aligned with the samples.
- sample_current  in  16  signed board current, A.
- sample_voltage  in  16  signed gap voltage, V.
- result_valid  out  1  one-cycle strobe per finished pulse.
- result_type  out  2  0=OPEN 1=NORMAL 2=ARC 3=SHORT; held until the next strobe.
- ignition_delay  out  CNT_W  cycles from pulse start to breakdown confirmation; held.
- discharge_len  out  CNT_W  cycles spent in SPARK; held.
- gap_state  out  3  live FSM state code.
- short_alarm  out  1  level alarm.

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, FSM to IDLE, all counters and filters cleared. A reset mid-pulse discards the pulse and produces no result_valid.
- FSM states and codes: IDLE=0, OPEN=1, SPARK=2, SHORT=3, DONE=4. gap_state reflects the registered state.
- Single-cycle FSM, no input pipeline. Comparisons use signed arithmetic. Qualifier "cur_ok" = sample_current >= I_ON_TH. Qualifier "short_ok" = sample_voltage <= V_SHORT_TH.
- Debounce filter: a run counter increments while its qualifier is 1 and clears when it is 0. It confirms on the sample where run = DEBOUNCE.
- IDLE, pulse_on=1:
  - That sample is OPEN sample 1: delay_cnt <= 1, cur_ok filter is evaluated, next state OPEN.
  - If confirmation happens on that same sample (DEBOUNCE=1), apply the OPEN confirmation rules directly.
- OPEN:
  - delay_cnt increments per sample, saturating at all-ones.
  - On cur_ok confirmation, ignition_delay_int = delay_cnt including the current sample.
  - At confirmation, if short_ok then SHORT.
  - Otherwise SPARK, with arc_flag = (ignition_delay_int < ARC_DELAY).
- SPARK:
  - disch_cnt increments per sample, saturating.
  - A short_ok filter confirmation moves to SHORT; arc_flag is irrelevant from then on.
- SHORT: counters hold.
- pulse_on=0 sampled in OPEN, SPARK or SHORT:
  - Next state DONE.
  - result_type, ignition_delay and discharge_len are registered on that edge.
  - result_valid=1 for exactly the DONE cycle.
  - result_type: OPEN state gives 0; SPARK gives 1 or 2 depending on arc_flag; SHORT gives 3.
  - For an OPEN result, ignition_delay = delay_cnt and discharge_len = 0.
- DONE: always goes to IDLE. A pulse_on that is high during DONE is ignored until IDLE samples it, giving a 1-cycle minimum off-gap.
- Filters and counters clear on entry to OPEN. Filters also clear on every state change.
- short_alarm:
  - A short counter increments (saturating at SHORT_ALARM_N) on each SHORT result.
  - Any non-SHORT result clears it.
  - short_alarm = (short counter == SHORT_ALARM_N), registered together with result_valid.
- A simultaneous confirmation and pulse_on=0 resolves to DONE. The classification uses the pre-transition state, so the late confirmation is ignored.

Decomposition:
- Shared package holds:
  - result codes RES_OPEN/RES_NORMAL/RES_ARC/RES_SHORT;
  - FSM state encodings;
  - default thresholds (I_ON_TH, V_SHORT_TH) so the pulse generator and servo share them.
- One natural sub-module, consec_filter: a parameterised run counter with confirm output, instantiated for cur_ok and for short_ok.

Test Plan:
- Reset: assert rst mid-SPARK -> all outputs 0 immediately, gap_state=0, no result_valid after release.
- Normal spark:
  - Stimulus: pulse_on=1 for 50 samples; samples 1-20 V=80,I=0; samples 21-50 V=25,I=10; then pulse_on=0.
  - Required: result_valid one cycle; result_type=1; ignition_delay=23; discharge_len=27.
- Arc: V=25, I=10 from sample 1 for 30 samples -> result_type=2, ignition_delay=3, discharge_len=27.
- Short and alarm:
  - Stimulus: four pulses of V=2, I=30 for 20 samples each.
  - Required: each result_type=3; short_alarm rises with the 4th result_valid.
  - Follow-up: one normal pulse clears short_alarm with its result_valid.
- Open and glitch:
  - Stimulus: V=80 for 100 samples, with a 2-sample I=10 spike at samples 40-41.
  - Required: stays OPEN; result_type=0; ignition_delay=100; discharge_len=0.
- Spark-to-short: normal breakdown confirmed at delay 23, then V=2 from sample 40 -> SHORT confirmed at sample 42; result_type=3; discharge_len=19.
